// File: rtl/button_conditioner.sv
// N-channel push-button front end: synchroniser, debounce, edge pulses,
// long-press detection and auto-repeat, all registered in the MCLK domain.
module button_conditioner #(
  parameter int CHANNELS        = 4,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int LONG_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] btn_raw,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] long_press,
  output logic [CHANNELS-1:0] auto_repeat,
  output logic [CHANNELS-1:0] press_evt
);

  localparam int DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam bit REPEAT_EN = (REPEAT_CYCLES != 0);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_EN ? REPEAT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, HELD, LONG} hold_state_t;

  logic [CHANNELS-1:0] pressed_in;
  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;

  // Normalise polarity so that 1 always means pressed from here on.
  assign pressed_in = btn_raw ^ {CHANNELS{ACTIVE_LOW}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pressed_in;
      sync2 <= sync1;
    end
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [DEB_W-1:0]  deb_cnt;
    logic              level_q;
    logic              rise_q;
    logic              fall_q;
    logic              deb_done;
    logic              rise_evt;
    logic              fall_evt;
    hold_state_t       state;
    hold_state_t       state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_nxt;
    logic              long_nxt;
    logic              rep_nxt;
    logic              long_q;
    logic              rep_q;
    logic              evt_q;

    assign deb_done = (sync2[ch] != level_q) && (deb_cnt == DEB_LAST);
    assign rise_evt = deb_done & sync2[ch];
    assign fall_evt = deb_done & ~sync2[ch];

    // Any cycle that agrees with the current level restarts the stability count.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        deb_cnt <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        rise_q <= rise_evt;
        fall_q <= fall_evt;
        if (sync2[ch] == level_q) begin
          deb_cnt <= '0;
        end else if (deb_done) begin
          level_q <= sync2[ch];
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state    <= IDLE;
        hold_cnt <= '0;
        long_q   <= 1'b0;
        rep_q    <= 1'b0;
        evt_q    <= 1'b0;
      end else begin
        state    <= state_nxt;
        hold_cnt <= hold_cnt_nxt;
        long_q   <= long_nxt;
        rep_q    <= rep_nxt;
        evt_q    <= rise_evt | rep_nxt;
      end
    end

    // hold_cnt is reused: long-press timer in HELD, repeat period timer in LONG.
    always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = '0;
      case (state)
        IDLE: begin
          if (rise_evt) state_nxt = HELD;
        end
        HELD: begin
          if (hold_cnt == LONG_LAST) state_nxt = LONG;
          else hold_cnt_nxt = hold_cnt + 1'b1;
        end
        LONG: begin
          if (REPEAT_EN && (hold_cnt != REP_LAST)) hold_cnt_nxt = hold_cnt + 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
      if (fall_evt) begin
        state_nxt    = IDLE;
        hold_cnt_nxt = '0;
      end
    end

    always_comb begin
      long_nxt = (state == HELD) && (hold_cnt == LONG_LAST) && !fall_evt;
      rep_nxt  = REPEAT_EN && (state == LONG) && (hold_cnt == REP_LAST) && !fall_evt;
    end

    assign level[ch]       = level_q;
    assign rise[ch]        = rise_q;
    assign fall[ch]        = fall_q;
    assign long_press[ch]  = long_q;
    assign auto_repeat[ch] = rep_q;
    assign press_evt[ch]   = evt_q;
  end

endmodule
